regfile_write_arbiter: RTL

Shares the single register-file write port (regwrite/writereg/writedata) between two producers. The primary producer is pipeline writeback. The secondary is a multi-cycle unit (mul/div) whose results complete out of order with the pipeline. Secondary results are held in a small FIFO until the port is free. A bounded-wait counter prevents starvation by briefly stalling writeback. Read-side hazard flags let decode stall on registers whose results are still buffered.

---
 rtl/regfile_write_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the single register-file write port between pipeline writeback and
// a buffered multi-cycle unit, with bounded-wait anti-starvation and decode hazard flags.
module regfile_write_arbiter #(
  parameter int DEPTH       = 2,
  parameter int STALL_LIMIT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_valid,
  output logic        wb_ready,
  input  logic [4:0]  wb_reg,
  input  logic [31:0] wb_data,
  input  logic        mc_valid,
  output logic        mc_ready,
  input  logic [4:0]  mc_reg,
  input  logic [31:0] mc_data,
  input  logic [4:0]  readreg1,
  input  logic [4:0]  readreg2,
  output logic        hazard1,
  output logic        hazard2,
  output logic        regwrite,
  output logic [4:0]  writereg,
  output logic [31:0] writedata
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int WW = (STALL_LIMIT > 0) ? $clog2(STALL_LIMIT + 1) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [WW-1:0] LIMIT_C = WW'(STALL_LIMIT);

  logic [4:0]    reg_mem_r  [DEPTH];
  logic [31:0]   data_mem_r [DEPTH];
  logic [AW-1:0] rd_ptr_r;
  logic [AW-1:0] wr_ptr_r;
  logic [CW-1:0] count_r;
  logic [WW-1:0] wait_cnt_r;
  logic          regwrite_r;
  logic [4:0]    writereg_r;
  logic [31:0]   writedata_r;

  logic          fifo_empty_s;
  logic          pipe_stall_s;
  logic          wb_ready_s;
  logic          mc_ready_s;
  logic          wb_grant_s;
  logic          pop_s;
  logic          push_s;
  logic [CW-1:0] count_nxt_s;
  logic [WW-1:0] wait_nxt_s;
  logic          regwrite_nxt_s;
  logic [4:0]    writereg_nxt_s;
  logic [31:0]   writedata_nxt_s;
  logic [AW-1:0] offset_s;
  logic          entry_valid_s;
  logic          match1_s;
  logic          match2_s;

  // Grant decision: a saturated wait counter forces the FIFO head ahead of writeback.
  always_comb begin
    fifo_empty_s = (count_r == {CW{1'b0}});
    pipe_stall_s = (wait_cnt_r == LIMIT_C);
    if (reset) begin
      wb_ready_s = 1'b0;
      mc_ready_s = 1'b0;
    end else begin
      wb_ready_s = !pipe_stall_s;
      mc_ready_s = (count_r < DEPTH_C);
    end
    wb_grant_s = wb_valid & wb_ready_s;
    pop_s      = !reset & !fifo_empty_s & (pipe_stall_s | !wb_valid);
    push_s     = mc_valid & mc_ready_s & (mc_reg != 5'd0);
  end

  // Hazard search over occupied FIFO slots, including the head being popped now.
  always_comb begin
    match1_s      = 1'b0;
    match2_s      = 1'b0;
    offset_s      = {AW{1'b0}};
    entry_valid_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      offset_s      = AW'(i) - rd_ptr_r;
      entry_valid_s = ({1'b0, offset_s} < count_r);
      match1_s      = match1_s | (entry_valid_s & (reg_mem_r[i] == readreg1));
      match2_s      = match2_s | (entry_valid_s & (reg_mem_r[i] == readreg2));
    end
  end

  // Next-state values for occupancy, wait counter and the write-port register.
  always_comb begin
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CW'(1);
      2'b01:   count_nxt_s = count_r - CW'(1);
      default: count_nxt_s = count_r;
    endcase
    if (pop_s || fifo_empty_s) begin
      wait_nxt_s = {WW{1'b0}};
    end else if (wb_grant_s && (wait_cnt_r < LIMIT_C)) begin
      wait_nxt_s = wait_cnt_r + WW'(1);
    end else begin
      wait_nxt_s = wait_cnt_r;
    end
    // A writeback to r0 completes its handshake but never reaches the port.
    if (wb_grant_s && (wb_reg != 5'd0)) begin
      regwrite_nxt_s  = 1'b1;
      writereg_nxt_s  = wb_reg;
      writedata_nxt_s = wb_data;
    end else if (pop_s) begin
      regwrite_nxt_s  = 1'b1;
      writereg_nxt_s  = reg_mem_r[rd_ptr_r];
      writedata_nxt_s = data_mem_r[rd_ptr_r];
    end else begin
      regwrite_nxt_s  = 1'b0;
      writereg_nxt_s  = writereg_r;
      writedata_nxt_s = writedata_r;
    end
  end

  // Control state and registered write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_r    <= {AW{1'b0}};
      wr_ptr_r    <= {AW{1'b0}};
      count_r     <= {CW{1'b0}};
      wait_cnt_r  <= {WW{1'b0}};
      regwrite_r  <= 1'b0;
      writereg_r  <= 5'd0;
      writedata_r <= 32'd0;
    end else begin
      rd_ptr_r    <= pop_s ? (rd_ptr_r + AW'(1)) : rd_ptr_r;
      wr_ptr_r    <= push_s ? (wr_ptr_r + AW'(1)) : wr_ptr_r;
      count_r     <= count_nxt_s;
      wait_cnt_r  <= wait_nxt_s;
      regwrite_r  <= regwrite_nxt_s;
      writereg_r  <= writereg_nxt_s;
      writedata_r <= writedata_nxt_s;
    end
  end

  // FIFO storage; contents are only meaningful within the occupied window.
  always_ff @(posedge clk) begin
    if (push_s) begin
      reg_mem_r[wr_ptr_r]  <= mc_reg;
      data_mem_r[wr_ptr_r] <= mc_data;
    end
  end

  assign wb_ready  = wb_ready_s;
  assign mc_ready  = mc_ready_s;
  assign hazard1   = !reset & (readreg1 != 5'd0) & match1_s;
  assign hazard2   = !reset & (readreg2 != 5'd0) & match2_s;
  assign regwrite  = regwrite_r;
  assign writereg  = writereg_r;
  assign writedata = writedata_r;

endmodule
